fb_access_arbiter: RTL and testbench

//  Shares one single-port 32K x 8 frame-buffer memory (15-bit address) between
//  VGA pixel scan-out and the coprocessor's read/write port.
//  - Converts VGA next_x/next_y (640x480) to a 160x120 image address (4x4 pixel replication).
//  - VGA has strict priority. The coprocessor gets every idle slot.
//  - Read data is tagged through a pipeline so it returns to the correct requester.

---
 rtl/fb_access_arbiter.sv | 208 ++++++++++++++++++++
 tb/tb_fb_access_arbiter.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fb_access_arbiter.sv
// Frame-buffer access arbiter: VGA scan-out has strict priority over the coprocessor
// port on one single-port 32K x 8 memory. Optional feature macro: FB_OOB_BLANK_EN.
module fb_access_arbiter #(
    parameter int READ_LATENCY = 2,
    parameter int IMG_W        = 160,
    parameter int IMG_H        = 120,
    parameter int STARVE_LIMIT = 64
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        vga_req,
    input  logic [9:0]  vga_x,
    input  logic [9:0]  vga_y,
    output logic [7:0]  vga_pixel,
    output logic        vga_pixel_valid,
    input  logic        cp_req,
    input  logic        cp_we,
    input  logic [14:0] cp_addr,
    input  logic [7:0]  cp_wdata,
    output logic        cp_gnt,
    output logic [7:0]  cp_rdata,
    output logic        cp_rvalid,
    output logic        cp_starved,
    output logic        vga_overrun,
    output logic [14:0] mem_addr,
    output logic [7:0]  mem_wdata,
    output logic        mem_we,
    input  logic [7:0]  mem_q
);

    typedef enum logic [1:0] {
        SLOT_IDLE   = 2'd0,
        SLOT_VGA_RD = 2'd1,
        SLOT_CP_RD  = 2'd2,
        SLOT_CP_WR  = 2'd3
    } slot_t;

    typedef struct packed {
        logic vga;
        logic blank;
        logic cp;
    } tag_t;

`ifdef FB_OOB_BLANK_EN
    localparam logic OOB_BLANK = 1'b1;
`else
    localparam logic OOB_BLANK = 1'b0;
`endif

    localparam logic [9:0]  X_END    = 10'(IMG_W * 4);
    localparam logic [9:0]  Y_END    = 10'(IMG_H * 4);
    localparam logic [14:0] IMG_W_L  = 15'(IMG_W);
    localparam int          WAIT_W   = $clog2(STARVE_LIMIT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(STARVE_LIMIT);

    // Row offset as a sum of shifted copies of the row, one per set bit of the width.
    function automatic logic [14:0] row_offset(input logic [14:0] row);
        logic [14:0] acc;
        acc = 15'd0;
        for (int i = 0; i < 15; i++) begin
            if (IMG_W_L[i]) begin
                acc = acc + (row << i);
            end else begin
                acc = acc;
            end
        end
        return acc;
    endfunction

    logic [14:0]       vaddr_s;
    logic              oob_s;
    logic              blank_req_s;
    logic              vga_rd_s;
    logic              denied_s;
    slot_t             slot_next_s;
    slot_t             slot_r;
    logic              blank_pend_r;
    logic              prev_vga_r;
    tag_t              tag_in_s;
    tag_t              tag_out_s;
    tag_t              tag_r [READ_LATENCY];
    logic [WAIT_W-1:0] wait_r;
    logic [WAIT_W-1:0] wait_next_s;

    assign vaddr_s     = row_offset({7'd0, vga_y[9:2]}) + {7'd0, vga_x[9:2]};
    assign oob_s       = (vga_x >= X_END) | (vga_y >= Y_END);
    // A blanked VGA request frees the memory slot for the coprocessor.
    assign blank_req_s = OOB_BLANK & vga_req & oob_s;
    assign vga_rd_s    = vga_req & ~blank_req_s;
    assign cp_gnt      = cp_req & ~vga_rd_s & RESET;
    assign denied_s    = cp_req & ~cp_gnt;
    assign tag_out_s   = tag_r[READ_LATENCY-1];

    // Slot selection: VGA first, then the coprocessor, otherwise idle.
    always_comb begin
        slot_next_s = SLOT_IDLE;
        if (vga_rd_s) begin
            slot_next_s = SLOT_VGA_RD;
        end else if (cp_gnt) begin
            slot_next_s = cp_we ? SLOT_CP_WR : SLOT_CP_RD;
        end else begin
            slot_next_s = SLOT_IDLE;
        end
    end

    // Slot state and the registered memory command.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            slot_r       <= SLOT_IDLE;
            blank_pend_r <= 1'b0;
            mem_addr     <= 15'd0;
            mem_wdata    <= 8'd0;
            mem_we       <= 1'b0;
        end else begin
            slot_r       <= slot_next_s;
            blank_pend_r <= blank_req_s;
            case (slot_next_s)
                SLOT_VGA_RD: begin
                    mem_addr <= vaddr_s;
                    mem_we   <= 1'b0;
                end
                SLOT_CP_RD, SLOT_CP_WR: begin
                    mem_addr  <= cp_addr;
                    mem_we    <= cp_we;
                    mem_wdata <= cp_wdata;
                end
                default: begin
                    mem_we <= 1'b0;
                end
            endcase
        end
    end

    // Tag for the slot issued last cycle; blanked VGA requests still return a pixel.
    always_comb begin
        tag_in_s       = tag_t'(3'b000);
        tag_in_s.vga   = (slot_r == SLOT_VGA_RD) | blank_pend_r;
        tag_in_s.blank = blank_pend_r;
        tag_in_s.cp    = (slot_r == SLOT_CP_RD);
    end

    // Tag shift register tracking reads in flight through the memory.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            for (int i = 0; i < READ_LATENCY; i++) begin
                tag_r[i] <= tag_t'(3'b000);
            end
        end else begin
            tag_r[0] <= tag_in_s;
            for (int i = 1; i < READ_LATENCY; i++) begin
                tag_r[i] <= tag_r[i-1];
            end
        end
    end

    // Return stage: route registered memory data to the tagged owner.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            vga_pixel       <= 8'd0;
            vga_pixel_valid <= 1'b0;
            cp_rdata        <= 8'd0;
            cp_rvalid       <= 1'b0;
        end else begin
            vga_pixel_valid <= tag_out_s.vga;
            cp_rvalid       <= tag_out_s.cp;
            if (tag_out_s.vga) begin
                vga_pixel <= tag_out_s.blank ? 8'h00 : mem_q;
            end else begin
                vga_pixel <= vga_pixel;
            end
            if (tag_out_s.cp) begin
                cp_rdata <= mem_q;
            end else begin
                cp_rdata <= cp_rdata;
            end
        end
    end

    // Saturating count of consecutive denied coprocessor cycles.
    always_comb begin
        wait_next_s = {WAIT_W{1'b0}};
        if (denied_s) begin
            if (wait_r == WAIT_MAX) begin
                wait_next_s = wait_r;
            end else begin
                wait_next_s = wait_r + WAIT_W'(1);
            end
        end else begin
            wait_next_s = {WAIT_W{1'b0}};
        end
    end

    // Sticky starvation and overrun flags.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            wait_r      <= {WAIT_W{1'b0}};
            cp_starved  <= 1'b0;
            prev_vga_r  <= 1'b0;
            vga_overrun <= 1'b0;
        end else begin
            wait_r      <= wait_next_s;
            cp_starved  <= cp_starved | (wait_next_s == WAIT_MAX);
            prev_vga_r  <= vga_req;
            vga_overrun <= vga_overrun | (vga_req & prev_vga_r);
        end
    end

endmodule

// File: tb/tb_fb_access_arbiter.sv
// Scoreboard bench for fb_access_arbiter with a behavioural frame-buffer memory.
module tb_fb_access_arbiter;

    localparam int RL = 2;

    typedef struct {
        logic [7:0] data;
        int         due;
    } sb_t;

    logic        clk;
    logic        rst_n;
    logic        vga_req;
    logic [9:0]  vga_x;
    logic [9:0]  vga_y;
    logic [7:0]  vga_pixel;
    logic        vga_pixel_valid;
    logic        cp_req;
    logic        cp_we;
    logic [14:0] cp_addr;
    logic [7:0]  cp_wdata;
    logic        cp_gnt;
    logic [7:0]  cp_rdata;
    logic        cp_rvalid;
    logic        cp_starved;
    logic        vga_overrun;
    logic [14:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_we;
    logic [7:0]  mem_q;

    logic [7:0]  mem [32768];
    bit          written [32768];
    logic [7:0]  rd_pipe [RL];

    int          n_checks;
    int          n_errors;
    int          cyc;
    sb_t         vga_sb [$];
    sb_t         cp_sb [$];
    logic [7:0]  exp_wr [int];
    logic [14:0] exp_addr;
    logic        exp_we;
    logic [7:0]  exp_wdata;
    int          exp_wait;
    logic        exp_starved;
    logic        exp_overrun;
    logic        prev_vr;

    fb_access_arbiter #(
        .READ_LATENCY(RL),
        .IMG_W(160),
        .IMG_H(120),
        .STARVE_LIMIT(64)
    ) dut (
        .CLK(clk),
        .RESET(rst_n),
        .vga_req(vga_req),
        .vga_x(vga_x),
        .vga_y(vga_y),
        .vga_pixel(vga_pixel),
        .vga_pixel_valid(vga_pixel_valid),
        .cp_req(cp_req),
        .cp_we(cp_we),
        .cp_addr(cp_addr),
        .cp_wdata(cp_wdata),
        .cp_gnt(cp_gnt),
        .cp_rdata(cp_rdata),
        .cp_rvalid(cp_rvalid),
        .cp_starved(cp_starved),
        .vga_overrun(vga_overrun),
        .mem_addr(mem_addr),
        .mem_wdata(mem_wdata),
        .mem_we(mem_we),
        .mem_q(mem_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] init_val(input logic [14:0] a);
        return a[7:0] ^ {1'b0, a[14:8]} ^ 8'h5A;
    endfunction

    // Memory: registered address, RL cycles to valid data.
    always @(posedge clk) begin
        if (mem_we) begin
            mem[mem_addr]     <= mem_wdata;
            written[mem_addr] <= 1'b1;
        end
        rd_pipe[0] <= written[mem_addr] ? mem[mem_addr] : init_val(mem_addr);
        for (int i = 1; i < RL; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign mem_q = rd_pipe[RL-1];

    function automatic logic [7:0] mem_val(input logic [14:0] a);
        if (exp_wr.exists(int'(a))) return exp_wr[int'(a)];
        return init_val(a);
    endfunction

    function automatic logic [14:0] model_vaddr(input logic [9:0] x, input logic [9:0] y);
        int v;
        v = (int'(y) / 4) * 160 + int'(x) / 4;
        return 15'(v);
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", tag, obs, exp, cyc);
        end
    endtask

    task automatic monitor();
        sb_t e;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (vga_pixel_valid) begin
                    if (vga_sb.size() == 0) begin
                        check_eq("vga_spurious_strobe", 32'(vga_pixel_valid), 32'd0);
                    end else begin
                        e = vga_sb.pop_front();
                        check_eq("vga_pixel", 32'(vga_pixel), 32'(e.data));
                        check_eq("vga_latency", 32'(cyc), 32'(e.due));
                    end
                end
                if (cp_rvalid) begin
                    if (cp_sb.size() == 0) begin
                        check_eq("cp_spurious_strobe", 32'(cp_rvalid), 32'd0);
                    end else begin
                        e = cp_sb.pop_front();
                        check_eq("cp_rdata", 32'(cp_rdata), 32'(e.data));
                        check_eq("cp_latency", 32'(cyc), 32'(e.due));
                    end
                end
            end
        end
    endtask

    // One cycle: check last edge's effects, drive new inputs, predict this edge.
    task automatic step(input logic vr, input logic [9:0] x, input logic [9:0] y,
                        input logic cr, input logic we, input logic [14:0] a, input logic [7:0] d);
        logic [14:0] va;
        logic        blank;
        logic        vrd;
        logic        gnt;
        sb_t         e;
        @(negedge clk);
        check_eq("mem_addr", 32'(mem_addr), 32'(exp_addr));
        check_eq("mem_we", 32'(mem_we), 32'(exp_we));
        if (exp_we) check_eq("mem_wdata", 32'(mem_wdata), 32'(exp_wdata));
        check_eq("cp_starved", 32'(cp_starved), 32'(exp_starved));
        check_eq("vga_overrun", 32'(vga_overrun), 32'(exp_overrun));
        vga_req = vr; vga_x = x; vga_y = y;
        cp_req = cr; cp_we = we; cp_addr = a; cp_wdata = d;
        #1;
        va = model_vaddr(x, y);
`ifdef FB_OOB_BLANK_EN
        blank = vr && (x >= 10'd640 || y >= 10'd480);
`else
        blank = 1'b0;
`endif
        vrd = vr & ~blank;
        gnt = cr & ~vrd;
        check_eq("cp_gnt", 32'(cp_gnt), 32'(gnt));
        if (vr) begin
            e.data = blank ? 8'h00 : mem_val(va);
            e.due  = cyc + RL + 2;
            vga_sb.push_back(e);
        end
        if (vrd) begin
            exp_addr = va;
            exp_we   = 1'b0;
        end else if (gnt) begin
            exp_addr  = a;
            exp_we    = we;
            exp_wdata = d;
            if (we) begin
                exp_wr[int'(a)] = d;
            end else begin
                e.data = mem_val(a);
                e.due  = cyc + RL + 2;
                cp_sb.push_back(e);
            end
        end else begin
            exp_we = 1'b0;
        end
        if (cr && !gnt) begin
            if (exp_wait < 64) exp_wait++;
        end else begin
            exp_wait = 0;
        end
        if (exp_wait == 64) exp_starved = 1'b1;
        if (vr && prev_vr) exp_overrun = 1'b1;
        prev_vr = vr;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 10'd0, 10'd0, 1'b0, 1'b0, 15'd0, 8'd0);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        vga_req = 1'b0; vga_x = 10'd0; vga_y = 10'd0;
        cp_req = 1'b1; cp_we = 1'b0; cp_addr = 15'd0; cp_wdata = 8'd0;
        #1;
        check_eq("rst_cp_gnt", 32'(cp_gnt), 32'd0);
        cp_req = 1'b0;
        check_eq("rst_mem_addr", 32'(mem_addr), 32'd0);
        check_eq("rst_mem_we", 32'(mem_we), 32'd0);
        check_eq("rst_mem_wdata", 32'(mem_wdata), 32'd0);
        check_eq("rst_vga_pixel", 32'(vga_pixel), 32'd0);
        check_eq("rst_vga_valid", 32'(vga_pixel_valid), 32'd0);
        check_eq("rst_cp_rdata", 32'(cp_rdata), 32'd0);
        check_eq("rst_cp_rvalid", 32'(cp_rvalid), 32'd0);
        check_eq("rst_cp_starved", 32'(cp_starved), 32'd0);
        check_eq("rst_vga_overrun", 32'(vga_overrun), 32'd0);
        vga_sb.delete();
        cp_sb.delete();
        exp_addr = 15'd0; exp_we = 1'b0; exp_wdata = 8'd0;
        exp_wait = 0; exp_starved = 1'b0; exp_overrun = 1'b0; prev_vr = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        cyc = 0;
        rst_n = 1'b0;
        fork
            monitor();
            begin
                #200000;
                $display("FAIL watchdog: simulation time limit reached");
                $fatal(1);
            end
        join_none

        apply_reset();
        idle(2);

        // Largest in-range coordinate maps to the last image address.
        step(1'b1, 10'd639, 10'd479, 1'b0, 1'b0, 15'd0, 8'd0);
        @(posedge clk); #1;
        check_eq("vaddr_max", 32'(mem_addr), 32'd19199);
        idle(5);

        // Coprocessor write then read back.
        step(1'b0, 10'd0, 10'd0, 1'b1, 1'b1, 15'h0123, 8'hA5);
        @(posedge clk); #1;
        check_eq("wr_we_pulse", 32'(mem_we), 32'd1);
        check_eq("wr_data", 32'(mem_wdata), 32'hA5);
        step(1'b0, 10'd0, 10'd0, 1'b1, 1'b0, 15'h0123, 8'h00);
        @(posedge clk); #1;
        check_eq("wr_we_drop", 32'(mem_we), 32'd0);
        idle(5);

        // Simultaneous requests: VGA wins, coprocessor served next free cycle.
        step(1'b1, 10'd8, 10'd4, 1'b1, 1'b0, 15'h7FFF, 8'h00);
        @(posedge clk); #1;
        check_eq("collide_addr", 32'(mem_addr), 32'd162);
        step(1'b0, 10'd0, 10'd0, 1'b1, 1'b0, 15'h7FFF, 8'h00);
        idle(5);

        // Back-to-back interleaved VGA and coprocessor traffic.
        for (int i = 0; i < 24; i++) begin
            if (i % 2 == 0)
                step(1'b1, 10'($urandom_range(639)), 10'($urandom_range(479)),
                     1'b0, 1'b0, 15'd0, 8'd0);
            else
                step(1'b0, 10'd0, 10'd0, 1'b1, 1'($urandom_range(1)),
                     15'h0100 + 15'($urandom_range(3)), 8'($urandom));
        end
        step(1'b1, 10'd0, 10'd0, 1'b0, 1'b0, 15'd0, 8'd0);
        idle(1);
        step(1'b1, 10'd1023, 10'd1023, 1'b0, 1'b0, 15'd0, 8'd0);
        idle(1);
        step(1'b1, 10'd700, 10'd10, 1'b1, 1'b0, 15'h0055, 8'd0);
        idle(6);

        // Reset with two reads in flight: nothing may come back afterwards.
        step(1'b1, 10'd100, 10'd100, 1'b0, 1'b0, 15'd0, 8'd0);
        step(1'b0, 10'd0, 10'd0, 1'b1, 1'b0, 15'h0200, 8'd0);
        apply_reset();
        for (int i = 0; i < 6; i++) begin
            step(1'b0, 10'd0, 10'd0, 1'b0, 1'b0, 15'd0, 8'd0);
            check_eq("rst_no_vga_strobe", 32'(vga_pixel_valid), 32'd0);
            check_eq("rst_no_cp_strobe", 32'(cp_rvalid), 32'd0);
        end

        // VGA held with the coprocessor waiting: overrun and starvation.
        for (int i = 0; i < 70; i++) begin
            step(1'b1, 10'((i * 8) % 640), 10'd8, 1'b1, 1'b0, 15'h0042, 8'd0);
            @(posedge clk); #1;
            if (i == 0) check_eq("overrun_first", 32'(vga_overrun), 32'd0);
            if (i == 1) check_eq("overrun_second", 32'(vga_overrun), 32'd1);
            if (i == 62) check_eq("starved_at_63", 32'(cp_starved), 32'd0);
            if (i == 63) check_eq("starved_at_64", 32'(cp_starved), 32'd1);
        end
        step(1'b0, 10'd0, 10'd0, 1'b1, 1'b0, 15'h0042, 8'd0);
        idle(8);

        check_eq("vga_sb_drained", 32'(vga_sb.size()), 32'd0);
        check_eq("cp_sb_drained", 32'(cp_sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
